bp_be_rollback_queue: RTL and testbench
=======================================

// Module: bp_be_rollback_queue
// PURPOSE
//  Parametrised FE-to-BE instruction queue with speculative read and multi-entry commit.
//  Sits between the FE queue input and the scheduler, and takes over the clr/deq/roll semantics from the director.
//  Entries are retained after speculative read (yumi) until committed (deq).
//  roll replays everything read since the last commit; clr flushes all entries.
// PARAMETERS
//  width_p      64  entry width in bits (fe_queue_width_lp at integration)
//  els_p        8   entry count; power of two, >=2
//  deq_width_p  2   max entries committed per cycle; 1..els_p
// PORTS
//  clk_i       in   1                       clock
//  reset_n_i   in   1                       async active-low reset
//  data_i      in   width_p                 enqueue data
//  v_i         in   1                       enqueue valid
//  ready_o     out  1                       enqueue ready; enqueue fires on v_i & ready_o
//  data_o      out  width_p                 head entry at speculative read pointer
//  v_o         out  1                       data_o valid
//  yumi_i      in   1                       speculative dequeue; legal only when v_o=1
//  deq_i       in   1                       commit request
//  deq_cnt_i   in   $clog2(deq_width_p+1)   entries to commit this cycle
//  roll_i      in   1                       rewind read pointer to commit pointer
//  clr_i       in   1                       discard all entries
//  count_o     out  $clog2(els_p+1)         occupied entries (wptr-cptr)
//  spec_cnt_o  out  $clog2(els_p+1)         unread entries (wptr-rptr)
//  full_o      out  1                       count_o==els_p
//  empty_o     out  1                       count_o==0
//  err_o       out  1                       sticky over-commit flag
// BEHAVIOUR
//  - Pointers wptr, rptr, cptr: $clog2(els_p)+1 bits each, MSB is the wrap bit.
//    Differences are taken mod 2^(ptr width).
//  - Invariant: cptr <= rptr <= wptr in queue order.
//  - Storage: register array, not reset. data_o = mem[rptr] combinationally; don't-care when v_o=0.
//  - All outputs are derived from registered state only; no same-cycle dependence on any input.
//    ready_o = !full_o. v_o = (rptr!=wptr).
//  - Enqueue latency: an entry written in cycle t is visible on v_o/data_o in t+1. No bypass.
//  - Occupancy: space is counted against cptr.
//    Read-but-uncommitted entries hold slots, so ready_o stays 0 until a deq frees space.
//  - Per-cycle update, priority clr_i > roll_i > normal:
//    clr_i:  wptr=rptr=cptr=0. Enqueue, yumi and deq in the same cycle are dropped; err_o unchanged.
//    roll_i: commit is applied first (cptr += n); then rptr = new cptr; yumi_i ignored; enqueue honoured.
//    normal: wptr += fire_enq; rptr += yumi_i; cptr += n.
//  - n = deq_i ? min(deq_cnt_i, rptr-cptr) : 0.
//    rptr here is the pre-update value, so this cycle's yumi is not committable.
//    If deq_cnt_i > rptr-cptr: commit is clamped and err_o is set (sticky until reset).
//    deq_i with deq_cnt_i==0 is a no-op.
//    deq_cnt_i > deq_width_p is illegal; the bench asserts it is never driven.
//  - Simultaneous enqueue and commit when full: ready_o is already 0, so no enqueue occurs.
//    Space appears the next cycle.
//  - Wrap-around: a pointer rolling from els_p-1 to 0 toggles its MSB.
//    full = (low bits equal, MSB differs); empty = (pointers identical).
//  - Reset, asynchronous and at any time including mid-roll:
//    pointers=0, ready_o=1, v_o=0, full_o=0, empty_o=1, count_o=0, spec_cnt_o=0, err_o=0.
//    Release is synchronised externally.
// TESTING
//  1. Reset; enqueue A,B,C on back-to-back cycles -> v_o=1 one cycle after A with data_o=A;
//     yumi x3 -> v_o=0, count_o=3, spec_cnt_o=0.
//  2. Enqueue 8 (els_p=8) -> full_o=1, ready_o=0; yumi all 8 -> ready_o still 0;
//     deq cnt=2 -> next cycle ready_o=1, count_o=6.
//  3. Enqueue E0..E4; yumi x4; deq cnt=1; then roll -> data_o=E1, spec_cnt_o=4, count_o=4.
//  4. Same as 3 but deq cnt=2 in the roll cycle -> data_o=E2, count_o=3, spec_cnt_o=3.
//  5. clr_i with v_i=1 and yumi_i=1 -> next cycle empty_o=1, count_o=0, v_o=0; the new entry is lost.
//  6. yumi x2 then deq cnt=3 (deq_width_p>=3) -> cptr advances 2, err_o=1 and stays 1 until reset_n_i low.
//  7. Random enq/yumi/deq/roll over 200 entries (>20 wraps) -> committed stream matches a reference FIFO in order.
//     No v_o glitch across the wrap.

Source files
------------

// File: rtl/bp_be_rollback_queue.sv
// FE-to-BE instruction queue with speculative read, rollback and multi-entry commit.
// Entries stay resident after yumi until committed by deq; roll replays uncommitted reads.
module bp_be_rollback_queue #(
  parameter int unsigned width_p     = 64,
  parameter int unsigned els_p       = 8,
  parameter int unsigned deq_width_p = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [width_p-1:0]               data_i,
  input  logic                             v_i,
  output logic                             ready_o,
  output logic [width_p-1:0]               data_o,
  output logic                             v_o,
  input  logic                             yumi_i,
  input  logic                             deq_i,
  input  logic [$clog2(deq_width_p+1)-1:0] deq_cnt_i,
  input  logic                             roll_i,
  input  logic                             clr_i,
  output logic [$clog2(els_p+1)-1:0]       count_o,
  output logic [$clog2(els_p+1)-1:0]       spec_cnt_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             err_o
);

  localparam int unsigned addr_w_lp = $clog2(els_p);
  localparam int unsigned ptr_w_lp  = addr_w_lp + 1;
  localparam int unsigned cnt_w_lp  = $clog2(els_p + 1);
  localparam int unsigned dcnt_w_lp = $clog2(deq_width_p + 1);
  localparam int unsigned cmp_w_lp  = (ptr_w_lp > dcnt_w_lp) ? ptr_w_lp : dcnt_w_lp;

  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] cptr_q, cptr_d;
  logic                err_q, err_d;
  logic [width_p-1:0]  mem_q [els_p];

  logic [ptr_w_lp-1:0] used, unread, uncommitted, n;
  logic [cmp_w_lp-1:0] req_ext, avail_ext;
  logic                over, fire_enq, fire_yumi;

  // Outputs depend on registered state only.
  always_comb begin
    used        = wptr_q - cptr_q;
    unread      = wptr_q - rptr_q;
    uncommitted = rptr_q - cptr_q;
    full_o      = (wptr_q[addr_w_lp-1:0] == cptr_q[addr_w_lp-1:0]) &&
                  (wptr_q[addr_w_lp] != cptr_q[addr_w_lp]);
    empty_o     = (wptr_q == cptr_q);
    ready_o     = !full_o;
    v_o         = (rptr_q != wptr_q);
    count_o     = cnt_w_lp'(used);
    spec_cnt_o  = cnt_w_lp'(unread);
    err_o       = err_q;
    data_o      = mem_q[rptr_q[addr_w_lp-1:0]];
  end

  always_comb begin
    req_ext   = cmp_w_lp'(deq_cnt_i);
    avail_ext = cmp_w_lp'(uncommitted);
    // Commit is bounded by entries already read before this edge.
    over      = deq_i && (req_ext > avail_ext);
    n         = '0;
    if (deq_i) begin
      n = over ? uncommitted : ptr_w_lp'(deq_cnt_i);
    end
    fire_enq  = v_i & ready_o;
    fire_yumi = yumi_i & v_o;

    wptr_d = wptr_q + ptr_w_lp'(fire_enq);
    cptr_d = cptr_q + n;
    rptr_d = roll_i ? cptr_d : (rptr_q + ptr_w_lp'(fire_yumi));
    err_d  = err_q | over;

    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
      err_d  = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire_enq && !clr_i) begin
      mem_q[wptr_q[addr_w_lp-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_bp_be_rollback_queue.sv
// Self-checking bench for bp_be_rollback_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_bp_be_rollback_queue;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 3;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  data_i;
  logic          v_i;
  logic          ready_o;
  logic [W-1:0]  data_o;
  logic          v_o;
  logic          yumi_i;
  logic          deq_i;
  logic [1:0]    deq_cnt_i;
  logic          roll_i;
  logic          clr_i;
  logic [3:0]    count_o;
  logic [3:0]    spec_cnt_o;
  logic          full_o;
  logic          empty_o;
  logic          err_o;

  bp_be_rollback_queue #(
    .width_p    (W),
    .els_p      (N),
    .deq_width_p(DW)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .deq_i     (deq_i),
    .deq_cnt_i (deq_cnt_i),
    .roll_i    (roll_i),
    .clr_i     (clr_i),
    .count_o   (count_o),
    .spec_cnt_o(spec_cnt_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: mq holds every resident entry oldest first; rd = entries read but uncommitted.
  logic [W-1:0] mq[$];
  logic [W-1:0] committed[$];
  logic [W-1:0] enq_log[$];
  int           rd   = 0;
  bit           merr = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".v_o"},      64'(v_o),        64'(sz != rd));
    check({tag, ".ready_o"},  64'(ready_o),    64'(sz < N));
    check({tag, ".count_o"},  64'(count_o),    64'(sz));
    check({tag, ".spec_cnt"}, 64'(spec_cnt_o), 64'(sz - rd));
    check({tag, ".full_o"},   64'(full_o),     64'(sz == N));
    check({tag, ".empty_o"},  64'(empty_o),    64'(sz == 0));
    check({tag, ".err_o"},    64'(err_o),      64'(merr));
    if (sz != rd) check({tag, ".data_o"}, 64'(data_o), 64'(mq[rd]));
  endtask

  task automatic model_update(input bit v, input logic [W-1:0] d, input bit y, input bit dq,
                              input int cnt, input bit rl, input bit cl);
    int  nc;
    bit  fire;
    if (cl) begin
      mq.delete();
      rd = 0;
      return;
    end
    fire = v && (mq.size() < N);
    nc   = 0;
    if (dq) begin
      nc = (cnt > rd) ? rd : cnt;
      if (cnt > rd) merr = 1'b1;
    end
    for (int i = 0; i < nc; i++) committed.push_back(mq.pop_front());
    rd -= nc;
    if (rl) rd = 0;
    else if (y && rd < mq.size()) rd++;
    if (fire) begin
      mq.push_back(d);
      enq_log.push_back(d);
    end
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d, input bit y, input bit dq,
                       input int cnt, input bit rl, input bit cl);
    assert (cnt <= DW);
    v_i = v; data_i = d; yumi_i = y; deq_i = dq; deq_cnt_i = 2'(cnt);
    roll_i = rl; clr_i = cl;
    #1 check_all("pre");
    @(posedge clk_i);
    model_update(v, d, y, dq, cnt, rl, cl);
    @(negedge clk_i);
    check_all("post");
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [W-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic yumi();
    cycle(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    cycle(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int cyc;
    int ncommit;
    reset_n_i = 1'b0;
    v_i = 0; data_i = '0; yumi_i = 0; deq_i = 0; deq_cnt_i = '0; roll_i = 0; clr_i = 0;
    #12;
    check_all("reset");
    check("reset.ready_const", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // 1: back-to-back enqueue, one-cycle visibility, speculative reads
    enq(16'h00A0);
    check("t1.v_after_A", 64'(v_o), 64'd1);
    check("t1.data_A", 64'(data_o), 64'h00A0);
    enq(16'h00B0);
    enq(16'h00C0);
    yumi(); yumi(); yumi();
    check("t1.count3", 64'(count_o), 64'd3);
    check("t1.spec0", 64'(spec_cnt_o), 64'd0);
    check("t1.v0", 64'(v_o), 64'd0);
    clear();

    // 2: fill, read all, space returns only after commit
    for (int i = 0; i < N; i++) enq(16'h0200 + 16'(i));
    check("t2.full", 64'(full_o), 64'd1);
    enq(16'hDEAD);
    for (int i = 0; i < N; i++) yumi();
    check("t2.ready_held", 64'(ready_o), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    check("t2.ready_back", 64'(ready_o), 64'd1);
    check("t2.count6", 64'(count_o), 64'd6);
    clear();

    // 3: commit one, then roll
    for (int i = 0; i < 5; i++) enq(16'h0E00 + 16'(i));
    for (int i = 0; i < 4; i++) yumi();
    cycle(1'b0, '0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("t3.data_E1", 64'(data_o), 64'h0E01);
    check("t3.spec4", 64'(spec_cnt_o), 64'd4);
    check("t3.count4", 64'(count_o), 64'd4);
    clear();

    // 4: commit two in the roll cycle
    for (int i = 0; i < 5; i++) enq(16'h0E00 + 16'(i));
    for (int i = 0; i < 4; i++) yumi();
    cycle(1'b0, '0, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    check("t4.data_E2", 64'(data_o), 64'h0E02);
    check("t4.count3", 64'(count_o), 64'd3);
    check("t4.spec3", 64'(spec_cnt_o), 64'd3);

    // 5: clr drops concurrent enqueue and yumi
    cycle(1'b1, 16'h5555, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    check("t5.empty", 64'(empty_o), 64'd1);
    check("t5.v0", 64'(v_o), 64'd0);

    // 6: over-commit clamps and sets sticky error
    enq(16'h0600); enq(16'h0601); enq(16'h0602);
    yumi(); yumi();
    cycle(1'b0, '0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    check("t6.err", 64'(err_o), 64'd1);
    check("t6.count1", 64'(count_o), 64'd1);
    clear();
    idle(); idle();
    check("t6.err_sticky", 64'(err_o), 64'd1);

    // async reset in the middle of a roll cycle
    enq(16'h0700); yumi();
    v_i = 1'b1; data_i = 16'h0701; roll_i = 1'b1;
    #3 reset_n_i = 1'b0;
    mq.delete(); rd = 0; merr = 1'b0;
    #1 check_all("rst_mid");
    check("rst_mid.err0", 64'(err_o), 64'd0);
    @(negedge clk_i);
    v_i = 1'b0; roll_i = 1'b0;
    reset_n_i = 1'b1;
    committed.delete(); enq_log.delete();

    // 7: random traffic across many wraps
    cyc = 0;
    while (enq_log.size() < 200 && cyc < 5000) begin
      bit v, y, dq, rl;
      v  = ($urandom % 4) != 0;
      y  = (mq.size() > rd) && ($urandom % 2 == 0);
      dq = ($urandom % 3) == 0;
      rl = ($urandom % 16) == 0;
      cycle(v, 16'($urandom), y, dq, int'($urandom_range(0, DW)), rl, 1'b0);
      cyc++;
    end
    cyc = 0;
    while (mq.size() != 0 && cyc < 500) begin
      cycle(1'b0, '0, mq.size() > rd, 1'b1, DW, 1'b0, 1'b0);
      cyc++;
    end
    check("t7.drained", 64'(empty_o), 64'd1);
    check("t7.enq_total", 64'(enq_log.size() >= 200), 64'd1);
    ncommit = committed.size();
    check("t7.commit_total", 64'(ncommit), 64'(enq_log.size()));
    for (int i = 0; i < ncommit && i < enq_log.size(); i++)
      check("t7.commit_order", 64'(committed[i]), 64'(enq_log[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
